// File: rtl/shim_sts_pkg.sv
// Shared widths, status group map and event-code helpers for the shim status path.
package shim_sts_pkg;

   localparam int CODE_W = 8;
   localparam int GRP_W  = 5;
   localparam int BIT_W  = 3;

   // Status group indices, in status-vector order
   localparam int GRP_SPI_OFF                = 0;
   localparam int GRP_OVER_THRESH            = GRP_SPI_OFF + 1;
   localparam int GRP_THRESH_UNDERFLOW       = GRP_OVER_THRESH + 1;
   localparam int GRP_THRESH_OVERFLOW        = GRP_THRESH_UNDERFLOW + 1;
   localparam int GRP_BAD_TRIG_CMD           = GRP_THRESH_OVERFLOW + 1;
   localparam int GRP_TRIG_DATA_BUF_OVERFLOW = GRP_BAD_TRIG_CMD + 1;
   localparam int NUM_DAC                    = 7;
   localparam int GRP_DAC0                   = GRP_TRIG_DATA_BUF_OVERFLOW + 1;
   localparam int NUM_ADC                    = 5;
   localparam int GRP_ADC0                   = GRP_DAC0 + NUM_DAC;
   localparam int STS_GROUPS                 = GRP_ADC0 + NUM_ADC;

   function automatic logic [CODE_W-1:0] sts_code(input logic [GRP_W-1:0] grp,
                                                  input logic [BIT_W-1:0] bit_idx);
      return {grp, bit_idx};
   endfunction

   // Index of the lowest set bit of a group byte; 0 when the byte is empty
   function automatic logic [BIT_W-1:0] lowest_bit(input logic [7:0] v);
      logic [BIT_W-1:0] idx;
      idx = '0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) idx = i[BIT_W-1:0];
      end
      return idx;
   endfunction

endpackage

// File: rtl/shim_sts_evt_fifo.sv
// First-word fall-through event FIFO built from registers. The head is read
// straight out of storage, so a pop exposes the next entry with no bubble.
module shim_sts_evt_fifo #(
   parameter int  DEPTH = 16,
   parameter int  WIDTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CNT_W = AW + 1
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_en;
   logic             rd_en;

   // Full/empty come from the registered count, so a simultaneous pop never frees room for a push
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign wr_en = push & ~full;
   assign rd_en = pop & ~empty;
   assign rdata = empty ? '0 : mem[rd_ptr];

   // Pointer and occupancy tracking; clear empties the FIFO and wins over push/pop
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage; contents are only observed through occupied slots
   always_ff @(posedge aclk) begin
      if (wr_en) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/shim_sts_event_ctrl.sv
// Status-event controller: rising-edge capture of the synchronized status
// groups, sticky/pending bookkeeping, round-robin scheduling of pending bits
// into the event FIFO, and first-fault capture with a level interrupt.
module shim_sts_event_ctrl
   import shim_sts_pkg::*;
#(
   parameter int GROUPS     = STS_GROUPS,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic [8*GROUPS-1:0] sts_in,
   input  logic                clear,
   output logic [8*GROUPS-1:0] sticky_sts,
   output logic [CODE_W-1:0]   evt_code,
   output logic                evt_valid,
   input  logic                evt_ready,
   output logic [CODE_W-1:0]   first_code,
   output logic                fault_irq,
   output logic [7:0]          drop_cnt,
   output logic                fifo_overflow
);

   localparam int               CNT_W    = $clog2(FIFO_DEPTH) + 1;
   localparam logic [GRP_W-1:0] PTR_LAST = GRP_W'(GROUPS - 1);

   logic [GROUPS-1:0][7:0] sts_q;
   logic [GROUPS-1:0][7:0] rise;
   logic [GROUPS-1:0][7:0] pending;
   logic [GROUPS-1:0][7:0] sticky;
   logic [GROUPS-1:0][7:0] push_clr;
   logic [GROUPS-1:0][7:0] dup;
   logic [GRP_W-1:0]       ptr;
   logic [7:0]             grp_pend;
   logic [BIT_W-1:0]       low_bit;
   logic                   grp_hit;
   logic                   do_push;
   logic [CODE_W-1:0]      push_code;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   fifo_pop;
   logic [CNT_W-1:0]       fifo_count;

   // sts_q starts at 0, so levels already high at reset release show up as rises
   assign rise       = sts_in & ~sts_q;
   assign sticky_sts = sticky;
   assign evt_valid  = (fifo_count != '0);
   assign fifo_pop   = evt_ready & ~fifo_empty;

   // Scheduler view of the group under the pointer; a bit being pushed this cycle is not a duplicate
   always_comb begin
      grp_pend  = pending[ptr];
      grp_hit   = |grp_pend;
      low_bit   = lowest_bit(grp_pend);
      do_push   = grp_hit & ~fifo_full;
      push_code = sts_code(ptr, low_bit);
      push_clr  = '0;
      if (do_push) push_clr[ptr][low_bit] = 1'b1;
      dup = rise & pending & ~push_clr;
   end

   // Edge-detect history keeps tracking the inputs even through a clear
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) sts_q <= '0;
      else          sts_q <= sts_in;
   end

   // Pending/sticky capture, pointer advance, drop counting and first-fault latch
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         pending       <= '0;
         sticky        <= '0;
         ptr           <= '0;
         first_code    <= '0;
         fault_irq     <= 1'b0;
         drop_cnt      <= '0;
         fifo_overflow <= 1'b0;
      end else if (clear) begin
         pending       <= '0;
         sticky        <= '0;
         ptr           <= '0;
         first_code    <= '0;
         fault_irq     <= 1'b0;
         drop_cnt      <= '0;
         fifo_overflow <= 1'b0;
      end else begin
         pending <= (pending & ~push_clr) | rise;
         sticky  <= sticky | rise;
         // A full FIFO parks the pointer on the group so its event is retried, never lost
         if (grp_hit && fifo_full) fifo_overflow <= 1'b1;
         else                      ptr <= (ptr == PTR_LAST) ? '0 : ptr + GRP_W'(1);
         if ((|dup) && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
         if (do_push && !fault_irq) begin
            first_code <= push_code;
            fault_irq  <= 1'b1;
         end
      end
   end

   shim_sts_evt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (CODE_W)
   ) u_evt_fifo (
      .aclk    (aclk),
      .aresetn (aresetn),
      .clear   (clear),
      .push    (do_push),
      .wdata   (push_code),
      .pop     (fifo_pop),
      .rdata   (evt_code),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

endmodule

// File: tb/tb_shim_sts_event_ctrl.sv
// Bench for shim_sts_event_ctrl: directed scenarios plus randomized traffic,
// all compared cycle by cycle against a queue-based behavioural model.
module tb_shim_sts_event_ctrl;

   localparam int G     = 18;
   localparam int NB    = 8 * G;
   localparam int DEPTH = 16;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic [NB-1:0] sts_in;
   logic          clear;
   logic          evt_ready;
   logic [NB-1:0] sticky_sts;
   logic [7:0]    evt_code;
   logic          evt_valid;
   logic [7:0]    first_code;
   logic          fault_irq;
   logic [7:0]    drop_cnt;
   logic          fifo_overflow;

   int n_chk  = 0;
   int n_fail = 0;

   // behavioural model state
   logic [NB-1:0] m_stsq;
   logic [NB-1:0] m_pend;
   logic [NB-1:0] m_sticky;
   int            m_ptr;
   logic [7:0]    m_q[$];
   logic [7:0]    m_first;
   logic          m_fault;
   int            m_drop;
   logic          m_ovf;

   logic [7:0]    obs_pop[$];

   shim_sts_event_ctrl #(
      .GROUPS     (G),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .sts_in        (sts_in),
      .clear         (clear),
      .sticky_sts    (sticky_sts),
      .evt_code      (evt_code),
      .evt_valid     (evt_valid),
      .evt_ready     (evt_ready),
      .first_code    (first_code),
      .fault_irq     (fault_irq),
      .drop_cnt      (drop_cnt),
      .fifo_overflow (fifo_overflow)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_stsq   = '0;
      m_pend   = '0;
      m_sticky = '0;
      m_ptr    = 0;
      m_q.delete();
      m_first  = '0;
      m_fault  = 1'b0;
      m_drop   = 0;
      m_ovf    = 1'b0;
   endtask

   // One clock of the reference: event code is simply group*8+bit
   task automatic model_step();
      logic [NB-1:0] rise;
      logic          popping;
      logic          dup;
      int            lowest;
      int            hit;
      rise   = sts_in & ~m_stsq;
      m_stsq = sts_in;
      if (clear) begin
         m_pend   = '0;
         m_sticky = '0;
         m_ptr    = 0;
         m_q.delete();
         m_first  = '0;
         m_fault  = 1'b0;
         m_drop   = 0;
         m_ovf    = 1'b0;
         return;
      end
      popping = evt_ready && (m_q.size() != 0);
      lowest  = -1;
      hit     = -1;
      for (int b = 7; b >= 0; b--) if (m_pend[m_ptr*8 + b]) lowest = b;
      if (lowest < 0) m_ptr = (m_ptr + 1) % G;
      else if (m_q.size() < DEPTH) begin
         hit   = m_ptr * 8 + lowest;
         m_ptr = (m_ptr + 1) % G;
      end else m_ovf = 1'b1;
      dup = 1'b0;
      for (int i = 0; i < NB; i++) if (rise[i] && m_pend[i] && i != hit) dup = 1'b1;
      if (dup && m_drop < 255) m_drop++;
      if (hit >= 0) begin
         m_pend[hit] = 1'b0;
         if (!m_fault) begin
            m_first = 8'(hit);
            m_fault = 1'b1;
         end
      end
      m_pend   = m_pend | rise;
      m_sticky = m_sticky | rise;
      if (popping) void'(m_q.pop_front());
      if (hit >= 0) m_q.push_back(8'(hit));
   endtask

   task automatic compare_all();
      chk("evt_valid", evt_valid, m_q.size() != 0);
      if (m_q.size() != 0) chk("evt_code", evt_code, m_q[0]);
      chk("sticky_sts", sticky_sts, m_sticky);
      chk("first_code", first_code, m_first);
      chk("fault_irq", fault_irq, m_fault);
      chk("drop_cnt", drop_cnt, m_drop);
      chk("fifo_overflow", fifo_overflow, m_ovf);
   endtask

   task automatic cycle();
      if (evt_valid && evt_ready) obs_pop.push_back(evt_code);
      @(posedge aclk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      cycle();
      clear = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, evt_valid, 0);
      chk({tag, "_code"}, evt_code, 0);
      chk({tag, "_sticky"}, sticky_sts, 0);
      chk({tag, "_first"}, first_code, 0);
      chk({tag, "_irq"}, fault_irq, 0);
      chk({tag, "_drop"}, drop_cnt, 0);
      chk({tag, "_ovf"}, fifo_overflow, 0);
   endtask

   initial begin
      logic [NB-1:0] exp_sticky;
      logic [7:0]    exp_codes[$];
      logic          found;
      int            hits;
      int            idx;

      aresetn   = 1'b0;
      clear     = 1'b0;
      evt_ready = 1'b0;
      sts_in    = '0;
      sts_in[9] = 1'b1;
      m_reset();
      repeat (3) @(posedge aclk);
      #1;
      chk_all_zero("reset");
      aresetn = 1'b1;

      // level high at reset release is reported
      run(3);
      chk("seed_valid", evt_valid, 1);
      chk("seed_code", evt_code, 8'h09);
      chk("seed_first", first_code, 8'h09);
      chk("seed_irq", fault_irq, 1);

      // two rises in one group
      pulse_clear();
      evt_ready  = 1'b1;
      obs_pop.delete();
      sts_in[16] = 1'b1;
      sts_in[18] = 1'b1;
      run(45);
      exp_sticky     = '0;
      exp_sticky[16] = 1'b1;
      exp_sticky[18] = 1'b1;
      chk("simul_sticky", sticky_sts, exp_sticky);
      chk("simul_npop", obs_pop.size(), 2);
      if (obs_pop.size() >= 2) begin
         chk("simul_first", obs_pop[0], 8'h10);
         chk("simul_second", obs_pop[1], 8'h12);
      end

      // fairness: groups 3 and 17 become pending while ptr sits on 17
      found = 1'b0;
      for (int k = 0; k < 60 && !found; k++) begin
         if (m_ptr == 16) found = 1'b1;
         else cycle();
      end
      chk("fair_ptr_wait", found, 1);
      obs_pop.delete();
      sts_in[136] = 1'b1;
      sts_in[24]  = 1'b1;
      run(40);
      chk("fair_npop", obs_pop.size(), 2);
      if (obs_pop.size() >= 2) begin
         chk("fair_first", obs_pop[0], 8'h88);
         chk("fair_second", obs_pop[1], 8'h18);
      end

      // FIFO full with 20 distinct rises, then drain
      sts_in    = '0;
      evt_ready = 1'b0;
      cycle();
      pulse_clear();
      exp_codes.delete();
      for (int g = 0; g < G; g++) exp_codes.push_back(8'(g * 8 + 3));
      exp_codes.push_back(8'h05);
      exp_codes.push_back(8'h0E);
      foreach (exp_codes[j]) sts_in[exp_codes[j]] = 1'b1;
      run(60);
      chk("full_ovf", fifo_overflow, 1);
      chk("full_valid", evt_valid, 1);
      obs_pop.delete();
      evt_ready = 1'b1;
      run(120);
      chk("full_npop", obs_pop.size(), 20);
      foreach (exp_codes[j]) begin
         hits = 0;
         foreach (obs_pop[k]) if (obs_pop[k] == exp_codes[j]) hits++;
         chk("full_code_once", hits, 1);
      end
      chk("full_drop", drop_cnt, 0);

      // duplicate rise on a bit stuck pending behind a full FIFO
      sts_in    = '0;
      evt_ready = 1'b0;
      cycle();
      pulse_clear();
      for (int g = 0; g < 16; g++) sts_in[g*8] = 1'b1;
      run(40);
      sts_in[141] = 1'b1;
      cycle();
      sts_in[141] = 1'b0;
      cycle();
      sts_in[141] = 1'b1;
      run(3);
      chk("dup_drop", drop_cnt, 1);
      obs_pop.delete();
      evt_ready = 1'b1;
      run(80);
      hits = 0;
      foreach (obs_pop[k]) if (obs_pop[k] == 8'h8D) hits++;
      chk("dup_once", hits, 1);
      chk("dup_npop", obs_pop.size(), 17);

      // clear together with a rise and a pop
      evt_ready  = 1'b0;
      sts_in[23] = 1'b1;
      sts_in[38] = 1'b1;
      run(25);
      evt_ready   = 1'b1;
      sts_in[100] = 1'b1;
      pulse_clear();
      chk_all_zero("clear");
      run(40);
      chk("clear_no_report", fault_irq, 0);
      chk("clear_no_valid", evt_valid, 0);

      // randomized traffic with occasional clears and one async reset
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            idx = int'($urandom_range(0, NB - 1));
            sts_in[idx] = ~sts_in[idx];
            if ($urandom_range(0, 3) == 0) begin
               idx = (idx & ~7) | int'($urandom_range(0, 7));
               sts_in[idx] = ~sts_in[idx];
            end
         end
         if (((i / 250) % 2) == 1) evt_ready = ($urandom_range(0, 3) == 0);
         else                      evt_ready = ($urandom_range(0, 3) != 0);
         clear = ($urandom_range(0, 299) == 0);
         cycle();
         clear = 1'b0;
         if (i == 1000) begin
            aresetn = 1'b0;
            #2;
            m_reset();
            compare_all();
            aresetn = 1'b1;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
